apb_sd_spi_ctrl: RTL and testbench

//  APB slave on the APB2 peripheral window that sequences the SD-card pads as a bit-banged GPIO port

---
 rtl/sd_spi_pkg.sv | 38 +++
 rtl/spi_shift_engine.sv | 132 +++++++++++++
 rtl/apb_sd_spi_ctrl.sv | 156 +++++++++++++++
 tb/tb_apb_sd_spi_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// ----------------------------------------------------------------------------
// sd_spi_pkg
// Shared definitions for the SD-pad APB controller:
//   - word-index offsets (paddr[7:2]) of the APB registers
//   - STAT bit positions
//   - shift-engine FSM state encoding
//   - helper that clamps a requested transfer length to the engine maximum
// ----------------------------------------------------------------------------
package sd_spi_pkg;

    // Register word indices (byte address >> 2)
    localparam logic [5:0] REG_OUT  = 6'h10;  // 0x40
    localparam logic [5:0] REG_DIR  = 6'h11;  // 0x44
    localparam logic [5:0] REG_PIN  = 6'h12;  // 0x48
    localparam logic [5:0] REG_DATA = 6'h13;  // 0x4C
    localparam logic [5:0] REG_CNT  = 6'h14;  // 0x50
    localparam logic [5:0] REG_STAT = 6'h15;  // 0x54
    localparam logic [5:0] REG_DIV  = 6'h16;  // 0x58

    // STAT bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_OVR  = 1;

    localparam logic [5:0] MAX_BITS = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } spi_state_e;

    // Requested lengths above 32 are clamped to a full word.
    function automatic logic [5:0] clamp_bits(input logic [5:0] n);
        return (n > MAX_BITS) ? MAX_BITS : n;
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// ----------------------------------------------------------------------------
// spi_shift_engine
// SPI mode-0, MSB-first shift engine, 1..32 bits per transfer.
// Each bit is a LOW phase (mosi presented) followed by a HIGH phase (sck=1,
// miso sampled at the entry edge); each phase lasts DIV+1 clk cycles, with
// DIV latched at phase entry so a change only affects the following phase.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start           one-cycle request (only honoured while idle)
//   start_bits      transfer length, already clamped to 1..32
//   tx              transmit word (stable for the whole transfer)
//   div             half-period divider value
//   miso            raw miso pad level
//   busy            transfer in progress
//   sck, mosi       engine-driven pad values
//   finish          high during the DONE cycle (pads handed back next edge)
//   xfer_done       one-cycle pulse after completion
//   bits_left       remaining bit count (CNT register view)
//   rx              receive word
// ----------------------------------------------------------------------------
module spi_shift_engine
    import sd_spi_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  start_bits,
    input  logic [31:0] tx,
    input  logic [7:0]  div,
    input  logic        miso,
    output logic        busy,
    output logic        sck,
    output logic        mosi,
    output logic        finish,
    output logic        xfer_done,
    output logic [5:0]  bits_left,
    output logic [31:0] rx
);

    spi_state_e  state_reg;
    logic [7:0]  div_cnt_reg;
    logic [7:0]  phase_div_reg;
    logic [5:0]  cnt_reg;
    logic [31:0] rx_reg;
    logic        sck_reg;
    logic        mosi_reg;
    logic        busy_reg;
    logic        done_reg;

    logic        phase_end;
    logic [4:0]  k_start;
    logic [4:0]  k_cur;
    logic [4:0]  k_next;

    assign phase_end = (div_cnt_reg == phase_div_reg);
    // Bit index k is always cnt-1: the count doubles as the MSB-first pointer.
    assign k_start   = 5'(start_bits - 6'd1);
    assign k_cur     = 5'(cnt_reg - 6'd1);
    assign k_next    = 5'(cnt_reg - 6'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            div_cnt_reg   <= '0;
            phase_div_reg <= '0;
            cnt_reg       <= '0;
            rx_reg        <= '0;
            sck_reg       <= 1'b0;
            mosi_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg     <= ST_LOW;
                        busy_reg      <= 1'b1;
                        cnt_reg       <= start_bits;
                        rx_reg        <= '0;
                        sck_reg       <= 1'b0;
                        mosi_reg      <= tx[k_start];
                        div_cnt_reg   <= '0;
                        phase_div_reg <= div;
                    end
                end
                ST_LOW: begin
                    if (phase_end) begin
                        state_reg     <= ST_HIGH;
                        sck_reg       <= 1'b1;
                        rx_reg[k_cur] <= miso;
                        div_cnt_reg   <= '0;
                        phase_div_reg <= div;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        cnt_reg       <= cnt_reg - 6'd1;
                        sck_reg       <= 1'b0;
                        div_cnt_reg   <= '0;
                        phase_div_reg <= div;
                        if (cnt_reg == 6'd1) begin
                            state_reg <= ST_DONE;
                        end else begin
                            state_reg <= ST_LOW;
                            mosi_reg  <= tx[k_next];
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_reg;
    assign sck       = sck_reg;
    assign mosi      = mosi_reg;
    assign finish    = (state_reg == ST_DONE);
    assign xfer_done = done_reg;
    assign bits_left = cnt_reg;
    assign rx        = rx_reg;

endmodule

// File: rtl/apb_sd_spi_ctrl.sv
// ----------------------------------------------------------------------------
// apb_sd_spi_ctrl
// APB slave driving the six SD pads as GPIO plus a hardware SPI shifter.
// Pad bit order: 0 miso, 1 mosi, 2 sck, 3 cs, 4 d2, 5 d1.
// Ports:
//   clk, reset        APB clock, asynchronous active-high reset
//   apb_*             APB2 slave interface (zero wait states, pready tied 1)
//   pad_in            raw pad levels
//   pad_out, pad_oe   pad output values and enables (oe = DIR register)
//   xfer_done         one-cycle pulse when an SPI transfer completes
// ----------------------------------------------------------------------------
module apb_sd_spi_ctrl
    import sd_spi_pkg::*;
#(
    parameter int         NPAD    = 6,
    parameter logic [7:0] DIV_RST = 8'd4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      apb_paddr,
    input  logic            apb_psel,
    input  logic            apb_penable,
    input  logic            apb_pwrite,
    input  logic [31:0]     apb_pwdata,
    output logic [31:0]     apb_prdata,
    output logic            apb_pready,
    input  logic [NPAD-1:0] pad_in,
    output logic [NPAD-1:0] pad_out,
    output logic [NPAD-1:0] pad_oe,
    output logic            xfer_done
);

    logic [NPAD-1:0] out_reg;
    logic [NPAD-1:0] dir_reg;
    logic [31:0]     tx_reg;
    logic [7:0]      div_reg;
    logic            ovr_reg;
    logic [NPAD-1:0] pin_meta_reg;
    logic [NPAD-1:0] pin_sync_reg;
    logic            access_d_reg;
    logic [31:0]     prdata_reg;

    logic [5:0]      reg_idx;
    logic            access;
    logic            wr_stb;
    logic            start;
    logic            busy;
    logic            eng_sck;
    logic            eng_mosi;
    logic            finish;
    logic [5:0]      bits_left;
    logic [31:0]     rx;
    logic [31:0]     rdata;
    logic            guarded_wr;
    logic            unused_addr;

    assign reg_idx     = apb_paddr[7:2];
    assign unused_addr = ^apb_paddr[1:0];
    assign access      = apb_psel & apb_penable;
    // One strobe per access even if penable is held for several cycles.
    assign wr_stb      = access & apb_pwrite & ~access_d_reg;
    assign start       = wr_stb && (reg_idx == REG_CNT) && !busy && (apb_pwdata[5:0] != 6'd0);
    assign guarded_wr  = wr_stb && busy &&
                         ((reg_idx == REG_DATA) || (reg_idx == REG_CNT) || (reg_idx == REG_DIV));

    spi_shift_engine u_engine (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_bits (clamp_bits(apb_pwdata[5:0])),
        .tx         (tx_reg),
        .div        (div_reg),
        .miso       (pad_in[0]),
        .busy       (busy),
        .sck        (eng_sck),
        .mosi       (eng_mosi),
        .finish     (finish),
        .xfer_done  (xfer_done),
        .bits_left  (bits_left),
        .rx         (rx)
    );

    always_comb begin
        rdata = 32'hFFFF_FFFF;
        case (reg_idx)
            REG_OUT:  rdata = 32'(out_reg);
            REG_DIR:  rdata = 32'(dir_reg);
            REG_PIN:  rdata = 32'(pin_sync_reg);
            REG_DATA: rdata = rx;
            REG_CNT:  rdata = 32'(bits_left);
            REG_STAT: rdata = 32'({ovr_reg, busy});
            REG_DIV:  rdata = 32'(div_reg);
            default:  rdata = 32'hFFFF_FFFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg      <= '0;
            dir_reg      <= '0;
            tx_reg       <= '0;
            div_reg      <= DIV_RST;
            ovr_reg      <= 1'b0;
            pin_meta_reg <= '0;
            pin_sync_reg <= '0;
            access_d_reg <= 1'b0;
            prdata_reg   <= 32'hFFFF_FFFF;
        end else begin
            access_d_reg <= access;
            pin_meta_reg <= pad_in;
            pin_sync_reg <= pin_meta_reg;

            // Read data is captured in the setup phase so it is stable for access.
            if (apb_psel && !apb_penable) begin
                prdata_reg <= rdata;
            end

            if (wr_stb) begin
                case (reg_idx)
                    REG_OUT:  out_reg <= apb_pwdata[NPAD-1:0];
                    REG_DIR:  dir_reg <= apb_pwdata[NPAD-1:0];
                    REG_DATA: if (!busy) tx_reg <= apb_pwdata;
                    REG_DIV:  if (!busy) div_reg <= apb_pwdata[7:0];
                    default:  ;
                endcase
            end

            // Hand the engine's final levels back to OUT on the same edge busy
            // drops, so mosi/sck do not glitch when the mux switches over.
            if (finish) begin
                out_reg[2:1] <= {eng_sck, eng_mosi};
            end

            if (wr_stb && (reg_idx == REG_STAT) && apb_pwdata[STAT_OVR]) begin
                ovr_reg <= 1'b0;
            end else if (guarded_wr) begin
                ovr_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NPAD; gi++) begin : g_pad
        if (gi == 1) begin : g_mosi
            assign pad_out[gi] = busy ? eng_mosi : out_reg[gi];
        end else if (gi == 2) begin : g_sck
            assign pad_out[gi] = busy ? eng_sck : out_reg[gi];
        end else begin : g_gpio
            assign pad_out[gi] = out_reg[gi];
        end
    end

    assign pad_oe     = dir_reg;
    assign apb_prdata = prdata_reg;
    assign apb_pready = 1'b1;

endmodule

// File: tb/tb_apb_sd_spi_ctrl.sv
// ----------------------------------------------------------------------------
// tb_apb_sd_spi_ctrl
// Directed bench for apb_sd_spi_ctrl: reset state, GPIO path, SPI transfers
// with loopback and fixed miso, overrun handling, length edge cases and an
// abort by reset in the middle of a transfer.
// ----------------------------------------------------------------------------
module tb_apb_sd_spi_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  apb_paddr;
    logic        apb_psel;
    logic        apb_penable;
    logic        apb_pwrite;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata;
    logic        apb_pready;
    logic [5:0]  pad_in;
    logic [5:0]  pad_out;
    logic [5:0]  pad_oe;
    logic        xfer_done;

    logic        loop_en;
    logic [5:0]  pad_drv;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Loopback ties miso to the mosi pad; otherwise pads follow pad_drv.
    assign pad_in = loop_en ? {pad_drv[5:1], pad_out[1]} : pad_drv;

    apb_sd_spi_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .apb_paddr   (apb_paddr),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pwrite  (apb_pwrite),
        .apb_pwdata  (apb_pwdata),
        .apb_prdata  (apb_prdata),
        .apb_pready  (apb_pready),
        .pad_in      (pad_in),
        .pad_out     (pad_out),
        .pad_oe      (pad_oe),
        .xfer_done   (xfer_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b1;
        apb_paddr = addr; apb_pwdata = data;
        @(posedge clk); #1;
        apb_penable = 1'b1;
        @(posedge clk); #1;
        apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
        @(posedge clk); #1;
        apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b0;
        apb_paddr = addr;
        @(posedge clk); #1;
        apb_penable = 1'b1;
        data = apb_prdata;
        @(posedge clk); #1;
        apb_psel = 1'b0; apb_penable = 1'b0;
    endtask

    // Follows a transfer until xfer_done (bounded), recording the cycle count
    // from the CNT write, sck rising edges, mosi at each rising edge, the
    // longest sck-high run and the number of xfer_done pulses.
    task automatic run_xfer(output int cycles, output int rises, output logic [31:0] mosi_bits,
                            output int high_max, output int pulses);
        logic prev_sck;
        int   run;
        cycles = 0; rises = 0; mosi_bits = '0; high_max = 0; pulses = 0;
        prev_sck = 1'b0; run = 0;
        while (pulses == 0 && cycles < 2000) begin
            @(posedge clk); #1;
            cycles++;
            if (pad_out[2]) begin
                run++;
                if (run > high_max) high_max = run;
                if (!prev_sck) begin
                    rises++;
                    mosi_bits = {mosi_bits[30:0], pad_out[1]};
                end
            end else begin
                run = 0;
            end
            prev_sck = pad_out[2];
            if (xfer_done) pulses++;
        end
        repeat (4) begin
            @(posedge clk); #1;
            if (xfer_done) pulses++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          cyc, rises, hmax, pulses;
        logic [31:0] mbits;

        reset = 1'b1;
        apb_paddr = '0; apb_psel = 1'b0; apb_penable = 1'b0;
        apb_pwrite = 1'b0; apb_pwdata = '0;
        loop_en = 1'b0; pad_drv = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_pad_oe", 32'(pad_oe), 32'h0);
        check("rst_pad_out", 32'(pad_out), 32'h0);
        check("rst_xfer_done", 32'(xfer_done), 32'h0);
        check("rst_prdata", apb_prdata, 32'hFFFF_FFFF);
        reset = 1'b0;
        apb_read(8'h58, rd); check("rst_div", rd, 32'h4);
        apb_read(8'h54, rd); check("rst_stat", rd, 32'h0);
        apb_read(8'h10, rd); check("unmapped_read", rd, 32'hFFFF_FFFF);
        apb_read(8'h50, rd); check("rst_cnt", rd, 32'h0);
        apb_read(8'h4C, rd); check("rst_rx", rd, 32'h0);

        // ---------------- GPIO ----------------
        apb_write(8'h44, 32'h3E);
        apb_write(8'h40, 32'h08);
        check("gpio_pad_oe", 32'(pad_oe), 32'h3E);
        check("gpio_pad_out", 32'(pad_out), 32'h08);
        pad_drv = 6'h01;
        repeat (2) @(posedge clk);
        apb_read(8'h48, rd); check("gpio_pin_01", rd, 32'h01);
        pad_drv = 6'h2A;
        repeat (2) @(posedge clk);
        apb_read(8'h48, rd); check("gpio_pin_2a", rd, 32'h2A);
        pad_drv = 6'h00;

        // ---------------- 8-bit loopback, DIV=0 ----------------
        apb_write(8'h58, 32'h0);
        apb_write(8'h4C, 32'hA5);
        loop_en = 1'b1;
        apb_write(8'h50, 32'd8);
        run_xfer(cyc, rises, mbits, hmax, pulses);
        check("x8_busy_cycles", 32'(cyc), 32'd17);
        check("x8_sck_rises", 32'(rises), 32'd8);
        check("x8_mosi_seq", mbits, 32'hA5);
        check("x8_done_pulses", 32'(pulses), 32'd1);
        apb_read(8'h4C, rd); check("x8_rx", rd, 32'hA5);
        apb_read(8'h40, rd); check("x8_out_handback", rd, 32'h0A);
        check("x8_pad_out_idle", 32'(pad_out), 32'h0A);
        apb_read(8'h50, rd); check("x8_cnt_end", rd, 32'h0);

        // ---------------- 32-bit, DIV=3, miso=1 ----------------
        loop_en = 1'b0;
        pad_drv = 6'h01;
        apb_write(8'h58, 32'h3);
        apb_write(8'h50, 32'd32);
        run_xfer(cyc, rises, mbits, hmax, pulses);
        check("x32_busy_cycles", 32'(cyc), 32'd257);
        check("x32_sck_rises", 32'(rises), 32'd32);
        check("x32_high_len", 32'(hmax), 32'd4);
        check("x32_done_pulses", 32'(pulses), 32'd1);
        apb_read(8'h4C, rd); check("x32_rx", rd, 32'hFFFF_FFFF);

        // ---------------- overrun ----------------
        pad_drv = 6'h00;
        loop_en = 1'b1;
        apb_write(8'h4C, 32'h3C);
        apb_write(8'h50, 32'd8);
        apb_write(8'h4C, 32'hFF);
        apb_read(8'h54, rd); check("ovr_stat_busy", rd, 32'h3);
        run_xfer(cyc, rises, mbits, hmax, pulses);
        check("ovr_done_pulses", 32'(pulses), 32'd1);
        apb_read(8'h4C, rd); check("ovr_tx_kept", rd, 32'h3C);
        apb_read(8'h54, rd); check("ovr_sticky", rd, 32'h2);
        apb_write(8'h54, 32'h2);
        apb_read(8'h54, rd); check("ovr_cleared", rd, 32'h0);

        // ---------------- CNT=0 no-op ----------------
        apb_write(8'h50, 32'd0);
        pulses = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (xfer_done) pulses++;
        end
        check("cnt0_no_done", 32'(pulses), 32'd0);
        apb_read(8'h54, rd); check("cnt0_stat", rd, 32'h0);

        // ---------------- CNT=40 clamps to 32 ----------------
        apb_write(8'h58, 32'h0);
        apb_write(8'h4C, 32'h1234_5678);
        apb_write(8'h50, 32'd40);
        run_xfer(cyc, rises, mbits, hmax, pulses);
        check("clamp_busy_cycles", 32'(cyc), 32'd65);
        check("clamp_sck_rises", 32'(rises), 32'd32);
        check("clamp_mosi_seq", mbits, 32'h1234_5678);
        apb_read(8'h4C, rd); check("clamp_rx", rd, 32'h1234_5678);

        // ---------------- reset mid-transfer ----------------
        apb_write(8'h58, 32'h3);
        apb_write(8'h50, 32'd8);
        repeat (10) @(posedge clk);
        #1;
        check("abort_sck_before", 32'(pad_out[2] | pad_out[1] | 1'b1), 32'h1);
        reset = 1'b1;
        #1;
        check("abort_pad_out", 32'(pad_out), 32'h0);
        @(posedge clk); #1;
        check("abort_xfer_done", 32'(xfer_done), 32'h0);
        reset = 1'b0;
        apb_read(8'h54, rd); check("abort_stat", rd, 32'h0);
        apb_read(8'h50, rd); check("abort_cnt", rd, 32'h0);
        apb_read(8'h58, rd); check("abort_div", rd, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
